// File: rtl/imem_program_loader_if.sv
// rtl/imem_program_loader_if.sv - byte stream in and instruction-memory write port out of the program loader
// master: the loader (consumes bytes, drives wr/addr/data_in); slave: stream source and memory side.
interface imem_program_loader_if #(
   parameter int ADDR_W = 12
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       data_in;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, wr, addr, data_in
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, wr, addr, data_in
   );
endinterface

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - packs a byte stream little-endian into words and writes them to instruction memory
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_program_loader #(
   parameter int ADDR_W    = 12,
   parameter int ADDR_STEP = 4,
   parameter int CNT_W     = 10
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   load_start,
   input  logic [ADDR_W-1:0]      load_base,
   input  logic [CNT_W-1:0]       load_words,
   imem_program_loader_if.master  bus,
   output logic                   cpu_hold,
   output logic                   busy,
   output logic                   load_done,
   output logic                   load_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE
   } state_t;

   // State entered once the last payload word is written (or immediately for an empty load).
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t S_FINAL = S_CHECK;
`else
   localparam state_t S_FINAL = S_DONE;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        idx_q;
   logic              ready;
   logic              accept;

   assign accept = bus.byte_valid && ready;

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_start)
               state_d = (load_words == '0) ? S_FINAL : S_COLLECT;
         end
         S_COLLECT: begin
            ready = 1'b1;
            if (accept && idx_q == 2'd3)
               state_d = S_WRITE;
         end
         S_WRITE: begin
            state_d = (cnt_q == CNT_W'(1)) ? S_FINAL : S_COLLECT;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            ready = 1'b1;
            if (accept)
               state_d = S_DONE;
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum_q;
   logic       err_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         csum_q <= 8'h00;
         err_q  <= 1'b0;
      end else begin
         if (state_q == S_IDLE && load_start) begin
            csum_q <= 8'h00;
            err_q  <= 1'b0;
         end else if (state_q == S_COLLECT && accept) begin
            csum_q <= csum_q ^ bus.byte_data;
         end else if (state_q == S_CHECK && accept) begin
            err_q <= (bus.byte_data != csum_q);
         end
      end
   end

   assign load_error = err_q;
`else
   assign load_error = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (load_start) begin
                  addr_q <= load_base;
                  cnt_q  <= load_words;
                  idx_q  <= 2'd0;
               end
            end
            S_COLLECT: begin
               if (accept) begin
                  data_q[{idx_q, 3'b000} +: 8] <= bus.byte_data;
                  idx_q                        <= idx_q + 2'd1;
               end
            end
            S_WRITE: begin
               // Wraps modulo 2^ADDR_W by width truncation.
               addr_q <= addr_q + ADDR_W'(ADDR_STEP);
               cnt_q  <= cnt_q - CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.byte_ready = ready;
   assign bus.wr         = (state_q == S_WRITE);
   assign bus.addr       = addr_q;
   assign bus.data_in    = data_q;
   assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
   assign cpu_hold       = busy;
   assign load_done      = (state_q == S_DONE);

endmodule
